// File: rtl/sparc_window_regfile.sv
// SPARC windowed integer register file: globals plus NWINDOWS overlapping
// windows, two registered read ports, one write port, CWP/WIM and traps.
module sparc_window_regfile #(
  parameter int DATA_W     = 32,
  parameter int NWINDOWS   = 8,
  parameter int REG_ADDR_W = 5,
  parameter int CWP_W      = $clog2(NWINDOWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0]     rd_val1,
  output logic [DATA_W-1:0]     rd_val2,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  save_req,
  input  logic                  restore_req,
  input  logic                  wim_wr_en,
  input  logic [NWINDOWS-1:0]   wim_wr_data,
  output logic [CWP_W-1:0]      cwp,
  output logic [NWINDOWS-1:0]   wim,
  output logic                  ovf_trap,
  output logic                  unf_trap,
  output logic                  win_err
);

  localparam int NREGS = 8 + 16 * NWINDOWS;
  localparam int PW    = $clog2(NREGS);
  localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);

  // Ins of window w are the outs of window w+1.
  function automatic logic [PW-1:0] phys(
    input logic [REG_ADDR_W-1:0] r,
    input logic [CWP_W-1:0]      w
  );
    int ri, wi, p;
    ri = int'(r);
    wi = int'(w);
    if (ri < 8)
      p = ri;
    else if (ri < 16)
      p = 8 + 16 * wi + (ri - 8);
    else if (ri < 24)
      p = 16 + 16 * wi + (ri - 16);
    else
      p = 8 + 16 * ((wi + 1) % NWINDOWS) + (ri - 24);
    return PW'(p);
  endfunction

  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [CWP_W-1:0]    cwp_q, cwp_d, cwp_dec, cwp_inc;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                err_q, err_d;
  logic [PW-1:0]       p1, p2, pw;
  logic                wr_ok;

  always_comb begin
    p1    = phys(rs1, cwp_q);
    p2    = phys(rs2, cwp_q);
    pw    = phys(wr_addr, cwp_q);
    wr_ok = wr_en && (wr_addr != '0);

    rd1_d = '0;
    rd2_d = '0;
    if (rs1 != '0)
      rd1_d = (wr_ok && pw == p1) ? wr_data : regs_q[p1];
    if (rs2 != '0)
      rd2_d = (wr_ok && pw == p2) ? wr_data : regs_q[p2];

    cwp_dec = (cwp_q == '0) ? CWP_MAX : cwp_q - 1'b1;
    cwp_inc = (cwp_q == CWP_MAX) ? '0 : cwp_q + 1'b1;

    cwp_d = cwp_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    err_d = 1'b0;
    unique case ({save_req, restore_req})
      2'b10: begin
        if (wim_q[cwp_dec]) ovf_d = 1'b1;
        else                cwp_d = cwp_dec;
      end
      2'b01: begin
        if (wim_q[cwp_inc]) unf_d = 1'b1;
        else                cwp_d = cwp_inc;
      end
      2'b11:   err_d = 1'b1;
      default: ;
    endcase

    wim_d = wim_wr_en ? wim_wr_data : wim_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      cwp_q <= '0;
      wim_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok)
        regs_q[pw] <= wr_data;
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  end

  assign rd_val1  = rd1_q;
  assign rd_val2  = rd2_q;
  assign cwp      = cwp_q;
  assign wim      = wim_q;
  assign ovf_trap = ovf_q;
  assign unf_trap = unf_q;
  assign win_err  = err_q;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Bench for sparc_window_regfile: directed scenarios plus random traffic
// against a window-structured reference model.
module tb_sparc_window_regfile;

  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1, rs2, wr_addr;
  logic [31:0]   rd_val1, rd_val2, wr_data;
  logic          wr_en, save_req, restore_req, wim_wr_en;
  logic [NW-1:0] wim_wr_data, wim;
  logic [2:0]    cwp;
  logic          ovf_trap, unf_trap, win_err;

  int vecs = 0;
  int errs = 0;

  logic [31:0] glb  [8];
  logic [31:0] outs [NW][8];
  logic [31:0] locs [NW][8];
  int          m_cwp;
  logic [NW-1:0] m_wim;
  logic [31:0] m_rd1, m_rd2;
  logic        m_ovf, m_unf, m_err;

  sparc_window_regfile #(
    .DATA_W(32), .NWINDOWS(NW), .REG_ADDR_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2),
    .rd_val1(rd_val1), .rd_val2(rd_val2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .save_req(save_req), .restore_req(restore_req),
    .wim_wr_en(wim_wr_en), .wim_wr_data(wim_wr_data),
    .cwp(cwp), .wim(wim),
    .ovf_trap(ovf_trap), .unf_trap(unf_trap), .win_err(win_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mread(int r, int w);
    if (r == 0) return 32'h0;
    if (r < 8)  return glb[r];
    if (r < 16) return outs[w][r-8];
    if (r < 24) return locs[w][r-16];
    return outs[(w+1)%NW][r-24];
  endfunction

  task automatic mwrite(int r, int w, logic [31:0] d);
    if (r == 0)      ;
    else if (r < 8)  glb[r] = d;
    else if (r < 16) outs[w][r-8] = d;
    else if (r < 24) locs[w][r-16] = d;
    else             outs[(w+1)%NW][r-24] = d;
  endtask

  // Advance model and DUT by one clock; outputs are settled on return.
  task automatic step();
    int n;
    if (reset) begin
      for (int i = 0; i < 8; i++) glb[i] = 0;
      for (int w = 0; w < NW; w++)
        for (int i = 0; i < 8; i++) begin
          outs[w][i] = 0;
          locs[w][i] = 0;
        end
      m_cwp = 0; m_wim = 0;
      m_rd1 = 0; m_rd2 = 0;
      m_ovf = 0; m_unf = 0; m_err = 0;
    end else begin
      if (wr_en) mwrite(int'(wr_addr), m_cwp, wr_data);
      m_rd1 = mread(int'(rs1), m_cwp);
      m_rd2 = mread(int'(rs2), m_cwp);
      m_ovf = 0; m_unf = 0; m_err = 0;
      if (save_req && restore_req) m_err = 1;
      else if (save_req) begin
        n = (m_cwp + NW - 1) % NW;
        if (m_wim[n]) m_ovf = 1; else m_cwp = n;
      end else if (restore_req) begin
        n = (m_cwp + 1) % NW;
        if (m_wim[n]) m_unf = 1; else m_cwp = n;
      end
      if (wim_wr_en) m_wim = wim_wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; wr_en = 0; save_req = 0; restore_req = 0;
    wim_wr_en = 0; rs1 = 0; rs2 = 0; wr_addr = 0;
    wr_data = 0; wim_wr_data = 0;
  endtask

  task automatic goto_cwp(int t);
    idle();
    for (int k = 0; k < NW && m_cwp != t; k++) begin
      restore_req = 1;
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step();
    step();
    vecs++;
    if (cwp !== 3'd0 || wim !== '0) begin
      errs++;
      $display("FAIL reset_state: cwp=%0d wim=%h want 0/0", cwp, wim);
    end
    vecs++;
    if ({ovf_trap, unf_trap, win_err} !== 3'b000) begin
      errs++;
      $display("FAIL reset_traps: got %b want 000",
               {ovf_trap, unf_trap, win_err});
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      step();
      vecs++;
      if (rd_val1 !== 32'h0 || rd_val2 !== 32'h0) begin
        errs++;
        $display("FAIL reset_read r%0d: got %h/%h want 0", r,
                 rd_val1, rd_val2);
      end
    end
  endtask

  task automatic test_basic_rw();
    idle();
    wr_en = 1; wr_addr = 9; wr_data = 32'hDEADBEEF;
    step();
    idle(); rs1 = 9;
    step();
    vecs++;
    if (rd_val1 !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL rw_r9: got %h want deadbeef", rd_val1);
    end
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    step();
    idle(); rs1 = 0; rs2 = 0;
    step();
    vecs++;
    if (rd_val1 !== 32'h0 || rd_val2 !== 32'h0) begin
      errs++;
      $display("FAIL rw_r0: got %h/%h want 0", rd_val1, rd_val2);
    end
  endtask

  task automatic test_alias();
    goto_cwp(1);
    wr_en = 1; wr_addr = 10; wr_data = 32'hA5A5A5A5;
    step();
    idle(); save_req = 1;
    step();
    vecs++;
    if (cwp !== 3'd0) begin
      errs++;
      $display("FAIL alias_save_cwp: got %0d want 0", cwp);
    end
    idle(); rs1 = 26;
    step();
    vecs++;
    if (rd_val1 !== 32'hA5A5A5A5) begin
      errs++;
      $display("FAIL alias_in_r26: got %h want a5a5a5a5", rd_val1);
    end
    idle(); restore_req = 1;
    step();
    idle(); rs2 = 10;
    step();
    vecs++;
    if (cwp !== 3'd1 || rd_val2 !== 32'hA5A5A5A5) begin
      errs++;
      $display("FAIL alias_restore: cwp=%0d r10=%h want 1/a5a5a5a5",
               cwp, rd_val2);
    end
  endtask

  task automatic test_bypass();
    idle();
    rs1 = 17; wr_en = 1; wr_addr = 17; wr_data = 32'h55;
    step();
    vecs++;
    if (rd_val1 !== 32'h55) begin
      errs++;
      $display("FAIL bypass_r17: got %h want 55", rd_val1);
    end
    goto_cwp(3);
    save_req = 1; wr_en = 1; wr_addr = 17; wr_data = 32'h66;
    step();
    vecs++;
    if (cwp !== 3'd2) begin
      errs++;
      $display("FAIL save_write_cwp: got %0d want 2", cwp);
    end
    idle(); restore_req = 1;
    step();
    idle(); rs1 = 17;
    step();
    vecs++;
    if (cwp !== 3'd3 || rd_val1 !== 32'h66) begin
      errs++;
      $display("FAIL save_write_r17: cwp=%0d r17=%h want 3/66",
               cwp, rd_val1);
    end
  endtask

  task automatic test_traps();
    goto_cwp(1);
    wim_wr_en = 1; wim_wr_data = 8'b0000_0001;
    step();
    idle(); save_req = 1;
    step();
    vecs++;
    if (ovf_trap !== 1'b1 || cwp !== 3'd1) begin
      errs++;
      $display("FAIL ovf: trap=%b cwp=%0d want 1/1", ovf_trap, cwp);
    end
    idle();
    step();
    vecs++;
    if (ovf_trap !== 1'b0) begin
      errs++;
      $display("FAIL ovf_pulse: got %b want 0", ovf_trap);
    end
    wim_wr_en = 1; wim_wr_data = 8'b1000_0000;
    step();
    goto_cwp(6);
    restore_req = 1;
    step();
    vecs++;
    if (unf_trap !== 1'b1 || cwp !== 3'd6) begin
      errs++;
      $display("FAIL unf: trap=%b cwp=%0d want 1/6", unf_trap, cwp);
    end
    idle();
    wim_wr_en = 1; wim_wr_data = 0;
    step();
    vecs++;
    if (unf_trap !== 1'b0 || wim !== 8'h00) begin
      errs++;
      $display("FAIL unf_pulse: trap=%b wim=%h want 0/00",
               unf_trap, wim);
    end
    goto_cwp(0);
    save_req = 1;
    step();
    vecs++;
    if (cwp !== 3'd7 || ovf_trap !== 1'b0) begin
      errs++;
      $display("FAIL save_wrap: cwp=%0d ovf=%b want 7/0", cwp, ovf_trap);
    end
  endtask

  task automatic test_win_err();
    idle();
    save_req = 1; restore_req = 1;
    step();
    vecs++;
    if (win_err !== 1'b1 || cwp !== 3'd7 || ovf_trap || unf_trap) begin
      errs++;
      $display("FAIL win_err: err=%b cwp=%0d want 1/7", win_err, cwp);
    end
    idle();
    step();
    vecs++;
    if (win_err !== 1'b0) begin
      errs++;
      $display("FAIL win_err_pulse: got %b want 0", win_err);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1; wr_addr = 9; wr_data = 32'h1;
    step();
    idle(); wim_wr_en = 1; wim_wr_data = 8'b0100_0000;
    step();
    idle(); reset = 1; save_req = 1;
    step();
    vecs++;
    if (cwp !== 3'd0 || wim !== 8'h00 || ovf_trap !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: cwp=%0d wim=%h ovf=%b want 0/00/0",
               cwp, wim, ovf_trap);
    end
    idle(); rs1 = 9;
    step();
    vecs++;
    if (rd_val1 !== 32'h0 || ovf_trap !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_reg: r9=%h ovf=%b want 0/0",
               rd_val1, ovf_trap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 79) == 0);
      wr_en       = ($urandom_range(0, 2) != 0);
      wr_addr     = 5'($urandom);
      wr_data     = $urandom;
      rs1         = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rs2         = 5'($urandom);
      save_req    = ($urandom_range(0, 3) == 0);
      restore_req = ($urandom_range(0, 3) == 0);
      wim_wr_en   = ($urandom_range(0, 9) == 0);
      wim_wr_data = NW'($urandom & $urandom & $urandom);
      step();
      vecs++;
      if (rd_val1 !== m_rd1 || rd_val2 !== m_rd2) begin
        errs++;
        $display("FAIL rand_read %0d: got %h/%h want %h/%h", i,
                 rd_val1, rd_val2, m_rd1, m_rd2);
      end
      vecs++;
      if (int'(cwp) != m_cwp || wim !== m_wim) begin
        errs++;
        $display("FAIL rand_win %0d: cwp=%0d wim=%h want %0d/%h", i,
                 cwp, wim, m_cwp, m_wim);
      end
      vecs++;
      if ({ovf_trap, unf_trap, win_err} !== {m_ovf, m_unf, m_err}) begin
        errs++;
        $display("FAIL rand_trap %0d: got %b want %b", i,
                 {ovf_trap, unf_trap, win_err}, {m_ovf, m_unf, m_err});
      end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic_rw();
    test_alias();
    test_bypass();
    test_traps();
    test_win_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
